// File: rtl/feature_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Package  : feature_classifier_pkg
// Brief    : Shared widths, constants and FSM encoding for the classifier.
// Revision : 1.0
// ============================================================================
package feature_classifier_pkg;

    localparam int FEAT_W     = 8;
    localparam int WGT_W      = 8;
    localparam int BIAS_W     = 16;
    localparam int ACC_W      = 20;
    localparam int NUM_FEAT   = 8;
    localparam int MARGIN_W   = 8;
    localparam int MARGIN_SAT = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/classifier_argmax.sv
`default_nettype none
// ============================================================================
// Module   : classifier_argmax
// Brief    : Running best/second-best score tracker with saturated margin.
// Revision : 1.0
// ============================================================================
module classifier_argmax
    import feature_classifier_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int CLS_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd,
    input  logic                    first,
    input  logic [CLS_W-1:0]        cls,
    input  logic signed [ACC_W-1:0] acc,
    output logic [CLS_W-1:0]        best_id_nxt,
    output logic signed [ACC_W-1:0] best_nxt,
    output logic [MARGIN_W-1:0]     margin_nxt
);

    localparam logic signed [ACC_W-1:0] C_MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    logic [CLS_W-1:0]        r_best_id;
    logic signed [ACC_W-1:0] r_best;
    logic signed [ACC_W-1:0] r_second;
    logic signed [ACC_W-1:0] w_second_nxt;

    // Strict '>' on best keeps the lower class index on ties.
    always_comb begin
        best_id_nxt  = r_best_id;
        best_nxt     = r_best;
        w_second_nxt = r_second;
        if (upd) begin
            if (first) begin
                best_id_nxt  = cls;
                best_nxt     = acc;
                w_second_nxt = C_MOST_NEG;
            end else if (acc > r_best) begin
                best_id_nxt  = cls;
                best_nxt     = acc;
                w_second_nxt = r_best;
            end else if (acc > r_second) begin
                w_second_nxt = acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_id <= '0;
            r_best    <= '0;
            r_second  <= '0;
        end else if (upd) begin
            r_best_id <= best_id_nxt;
            r_best    <= best_nxt;
            r_second  <= w_second_nxt;
        end
    end

    generate
        if (NUM_CLASSES == 1) begin : g_single
            assign margin_nxt = MARGIN_W'(MARGIN_SAT);
        end else begin : g_multi
            logic [ACC_W:0] w_diff;
            assign w_diff = {best_nxt[ACC_W-1], best_nxt}
                          - {w_second_nxt[ACC_W-1], w_second_nxt};
            assign margin_nxt = (w_diff > (ACC_W+1)'(MARGIN_SAT))
                              ? MARGIN_W'(MARGIN_SAT) : w_diff[MARGIN_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/feature_classifier.sv
`default_nettype none
// ============================================================================
// Module   : feature_classifier
// Brief    : Fetches 8 features, scores each class linearly, reports argmax.
// Revision : 1.0
// ============================================================================
module feature_classifier
    import feature_classifier_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int CLS_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [2:0]       feat_addr,
    input  logic [7:0]       feat_in,
    input  logic             w_we,
    input  logic [CLS_W+2:0] w_addr,
    input  logic [7:0]       w_data,
    input  logic             b_we,
    input  logic [CLS_W-1:0] b_addr,
    input  logic [15:0]      b_data,
    output logic             busy,
    output logic             done,
    output logic [CLS_W-1:0] class_id,
    output logic [19:0]      class_score,
    output logic [7:0]       margin
);

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]              r_cnt;
    logic [CLS_W-1:0]        r_cls;
    logic [2:0]              r_feat_addr;
    logic [FEAT_W-1:0]       r_feat [NUM_FEAT];
    logic signed [WGT_W-1:0] r_w    [NUM_CLASSES][NUM_FEAT];
    logic signed [BIAS_W-1:0] r_b   [NUM_CLASSES];
    logic signed [ACC_W-1:0] r_acc;
    logic [CLS_W-1:0]        r_class_id;
    logic [ACC_W-1:0]        r_class_score;
    logic [MARGIN_W-1:0]     r_margin;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_last_cls;
    logic                    w_coef_ok;
    logic [CLS_W-1:0]        w_wcls;
    logic signed [16:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_base;
    logic [CLS_W-1:0]        w_best_id_nxt;
    logic signed [ACC_W-1:0] w_best_nxt;
    logic [MARGIN_W-1:0]     w_margin_nxt;

    assign w_last_cls = (r_cls == CLS_W'(NUM_CLASSES - 1));
    assign w_coef_ok  = (r_state == ST_IDLE);
    assign w_wcls     = w_addr[CLS_W+2:3];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: if (r_cnt == 4'd8) w_state_nxt = ST_MAC;
            ST_MAC:   if (r_cnt == 4'd7) w_state_nxt = ST_CMP;
            ST_CMP:   w_state_nxt = w_last_cls ? ST_DONE : ST_MAC;
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = w_busy;
    assign done = w_done;

    // Phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE || r_state != w_state_nxt) r_cnt <= '0;
        else                                                   r_cnt <= r_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE)          r_cls <= '0;
        else if (r_state == ST_CMP && !w_last_cls) r_cls <= r_cls + CLS_W'(1);
    end

    // Address leads capture by one cycle; the sweep parks at 7.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE && start)) r_feat_addr <= '0;
        else if (r_state == ST_FETCH && r_feat_addr != 3'd7)
            r_feat_addr <= r_feat_addr + 3'd1;
    end

    assign feat_addr = r_feat_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FEAT; i++) r_feat[i] <= '0;
        end else if (r_state == ST_FETCH && r_cnt != 4'd0) begin
            r_feat[3'(r_cnt - 4'd1)] <= feat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_b[c] <= '0;
                for (int k = 0; k < NUM_FEAT; k++) r_w[c][k] <= '0;
            end
        end else if (w_coef_ok) begin
            if (w_we && int'(w_wcls) < NUM_CLASSES)
                r_w[w_wcls][w_addr[2:0]] <= w_data;
            if (b_we && int'(b_addr) < NUM_CLASSES)
                r_b[b_addr] <= b_data;
        end
    end

    // Feature is zero-extended so the 9x8 product stays signed.
    assign w_prod     = $signed({1'b0, r_feat[r_cnt[2:0]]}) * r_w[r_cls][r_cnt[2:0]];
    assign w_acc_base = (r_cnt == 4'd0)
                      ? {{(ACC_W-BIAS_W){r_b[r_cls][BIAS_W-1]}}, r_b[r_cls]}
                      : r_acc;

    always_ff @(posedge clk) begin
        if (rst)                    r_acc <= '0;
        else if (r_state == ST_MAC) r_acc <= w_acc_base + {{(ACC_W-17){w_prod[16]}}, w_prod};
    end

    classifier_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLS_W       (CLS_W)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .upd         (r_state == ST_CMP),
        .first       (r_cls == '0),
        .cls         (r_cls),
        .acc         (r_acc),
        .best_id_nxt (w_best_id_nxt),
        .best_nxt    (w_best_nxt),
        .margin_nxt  (w_margin_nxt)
    );

    // Result registers load on the final compare so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_class_id    <= '0;
            r_class_score <= '0;
            r_margin      <= '0;
        end else if (r_state == ST_CMP && w_last_cls) begin
            r_class_id    <= w_best_id_nxt;
            r_class_score <= w_best_nxt;
            r_margin      <= w_margin_nxt;
        end
    end

    assign class_id    = r_class_id;
    assign class_score = r_class_score;
    assign margin      = r_margin;

endmodule
`default_nettype wire

// File: tb/tb_feature_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_classifier
// Brief    : Randomised and directed checks against a score/argmax model.
// Revision : 1.0
// ============================================================================
module tb_feature_classifier;

    localparam int NUM_CLASSES = 4;
    localparam int CLS_W       = 2;
    localparam int LATENCY     = 9 + 9 * NUM_CLASSES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       feat_addr;
    logic [7:0]       feat_in = '0;
    logic             w_we = 1'b0;
    logic [CLS_W+2:0] w_addr = '0;
    logic [7:0]       w_data = '0;
    logic             b_we = 1'b0;
    logic [CLS_W-1:0] b_addr = '0;
    logic [15:0]      b_data = '0;
    logic             busy;
    logic             done;
    logic [CLS_W-1:0] class_id;
    logic [19:0]      class_score;
    logic [7:0]       margin;

    int mem [8];
    int m_w [NUM_CLASSES][8];
    int m_b [NUM_CLASSES];
    int n_checks = 0;
    int n_fail   = 0;

    feature_classifier #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLS_W       (CLS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .feat_addr   (feat_addr),
        .feat_in     (feat_in),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .busy        (busy),
        .done        (done),
        .class_id    (class_id),
        .class_score (class_score),
        .margin      (margin)
    );

    always #5 clk = ~clk;

    // Extractor read port: registered, one-cycle latency.
    always @(posedge clk) feat_in <= 8'(mem[feat_addr]);

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(output int cls, output int score, output int mg);
        int s [NUM_CLASSES];
        int sec;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            s[c] = m_b[c];
            for (int k = 0; k < 8; k++) s[c] += mem[k] * m_w[c][k];
        end
        cls = 0;
        for (int c = 1; c < NUM_CLASSES; c++) if (s[c] > s[cls]) cls = c;
        score = s[cls];
        if (NUM_CLASSES == 1) begin
            mg = 255;
        end else begin
            sec = -(1 << 30);
            for (int c = 0; c < NUM_CLASSES; c++) if (c != cls && s[c] > sec) sec = s[c];
            mg = (score - sec > 255) ? 255 : score - sec;
        end
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NUM_CLASSES; c++) begin
            m_b[c] = 0;
            for (int k = 0; k < 8; k++) m_w[c][k] = 0;
        end
    endtask

    task automatic load_coeffs();
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                w_we   = 1'b1;
                w_addr = {CLS_W'(c), 3'(k)};
                w_data = 8'(m_w[c][k]);
                // bias shares a cycle with a weight write
                b_we   = (k == 0);
                b_addr = CLS_W'(c);
                b_data = 16'(m_b[c]);
            end
        end
        @(negedge clk);
        w_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit inject);
        int exp_cls, exp_score, exp_mg;
        int cyc;
        bit busy_ok;
        logic [26:0] addr_seq, exp_seq;
        model(exp_cls, exp_score, exp_mg);
        for (int i = 0; i < 9; i++) exp_seq[i*3 +: 3] = 3'((i < 7) ? i : 7);
        addr_seq = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 200) begin
            if (cyc < 9) addr_seq[cyc*3 +: 3] = feat_addr;
            if (!busy) busy_ok = 1'b0;
            if (inject && cyc == 20) begin
                start  = 1'b1;
                w_we   = 1'b1;
                w_addr = {CLS_W'(1), 3'd0};
                w_data = 8'd50;
            end
            if (inject && cyc == 21) begin
                start = 1'b0;
                w_we  = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        w_we  = 1'b0;
        check_val({tag, ".latency"}, cyc, LATENCY);
        check_val({tag, ".busy"}, busy_ok, 1);
        check_val({tag, ".addr_sweep"}, addr_seq, exp_seq);
        check_val({tag, ".class_id"}, class_id, exp_cls);
        check_val({tag, ".score"}, $signed(class_score), exp_score);
        check_val({tag, ".margin"}, margin, exp_mg);
        // a start in the DONE cycle must be ignored
        if (inject) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, ".done_pulse"}, done, 0);
        check_val({tag, ".idle_after"}, busy, 0);
        check_val({tag, ".hold_id"}, class_id, exp_cls);
    endtask

    initial begin
        clear_model();
        for (int k = 0; k < 8; k++) mem[k] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst.class_id", class_id, 0);
        check_val("rst.score", class_score, 0);
        check_val("rst.margin", margin, 0);
        check_val("rst.done", done, 0);
        check_val("rst.busy", busy, 0);
        check_val("rst.feat_addr", feat_addr, 0);

        for (int k = 0; k < 8; k++) mem[k] = $urandom_range(0, 255);
        run_check("tie", 1'b0);

        m_b[0] = 10; m_b[1] = -5; m_b[2] = 300; m_b[3] = 7;
        load_coeffs();
        run_check("bias", 1'b0);

        clear_model();
        m_w[1][0] = 2;
        mem[0] = 100;
        for (int k = 1; k < 8; k++) mem[k] = 0;
        load_coeffs();
        run_check("feat", 1'b0);
        run_check("proto_inject", 1'b1);
        run_check("proto_after", 1'b0);

        // reset in FETCH aborts the run and clears coefficients
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            bit seen_done = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done) seen_done = 1'b1;
            end
            check_val("abort.no_done", seen_done, 0);
        end
        check_val("abort.class_id", class_id, 0);
        check_val("abort.score", class_score, 0);
        check_val("abort.margin", margin, 0);
        check_val("abort.busy", busy, 0);
        clear_model();
        run_check("abort.rerun", 1'b0);

        for (int k = 0; k < 8; k++) begin
            mem[k] = 255;
            m_w[0][k] = -128;
        end
        load_coeffs();
        run_check("neg", 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                m_b[c] = (r < 3) ? $urandom_range(0, 65535) - 32768 : $urandom_range(0, 200) - 100;
                for (int k = 0; k < 8; k++) m_w[c][k] = $urandom_range(0, 255) - 128;
            end
            for (int k = 0; k < 8; k++) mem[k] = $urandom_range(0, 255);
            load_coeffs();
            run_check($sformatf("rand%0d", r), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/feature_classifier.md
Name: feature_classifier

Overview:
- Downstream consumer of the feature extraction engine.
- On start, reads the 8 unsigned 8-bit features over the extractor's random-access read port.
- Computes one signed linear score per class: bias plus the dot product of the 8 features with that class's weights.
- Reports the argmax class, its score and a confidence margin. Weights and biases are loaded through a simple write port before inference.

Parameters:
- NUM_CLASSES, 4, number of output classes (1..8)
- CLS_W, 2, class index width (CLS_W = max(1, clog2(NUM_CLASSES)))
- NUM_FEAT, 8, features per vector (fixed at 8; matches extractor)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin inference
- feat_addr  out  3  feature index driven to extractor
- feat_in  in  8  unsigned feature; valid one cycle after feat_addr
- w_we  in  1  weight write strobe
- w_addr  in  CLS_W+3  {class, feature} weight index
- w_data  in  8  signed weight
- b_we  in  1  bias write strobe
- b_addr  in  CLS_W  class index for bias
- b_data  in  16  signed bias
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle result-valid pulse
- class_id  out  CLS_W  winning class
- class_score  out  20  signed score of winner
- margin  out  8  winner minus runner-up, unsigned, saturated at 255

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0, feat_addr 0, FSM IDLE; weight and bias registers cleared to 0. Reset mid-inference aborts, and no done is emitted.
- States: IDLE -> FETCH -> MAC -> CMP -> (MAC for the next class | DONE) -> IDLE.
- IDLE: start=1 is accepted. Inference uses the coefficient values held at acceptance.
- FETCH (9 cycles):
  - feat_addr steps 0..7 on successive cycles.
  - feat_in is captured one cycle after each address into local registers f[0..7].
  - feat_addr holds 7 on the last cycle.
- MAC (8 cycles per class): acc starts at sign-extended bias[c]; each cycle adds f[k]*w[c][k]. The feature is zero-extended to 9 bits and the product is 9x8 signed.
- CMP (1 cycle per class): updates best/second.
  - Ties keep the lower index: replace best only if acc > best.
  - Otherwise replace second if acc > second.
  - On class 0, best = acc and second = most-negative.
- DONE (1 cycle): done=1 and outputs update in this same cycle.
  - margin = min(best - second, 255).
  - If NUM_CLASSES = 1, margin = 255.
  - Outputs then hold until the next done or reset.
- Latency: done is high in the cycle after the (9 + 9*NUM_CLASSES)th rising edge following the edge that samples start. This is 45 edges for the default.
- Width: accumulator is 20-bit signed. Worst case |8*255*128| + 2^15 < 2^19, so no overflow is possible and no saturation is applied.
- Start while busy or in DONE is ignored.
- Coefficient writes:
  - Writes while busy are dropped.
  - Writes in IDLE take effect on the next edge.
  - w_we and b_we together are both honoured.
  - Out-of-range class addresses (>= NUM_CLASSES) are ignored.

Decomposition:
- Shared package: FEAT_W=8, WGT_W=8, BIAS_W=16, ACC_W=20, NUM_FEAT=8, FSM state encoding, and the MARGIN_SAT=255 constant.
- One natural sub-module: classifier_argmax. It is the running best/second-best tracker with tie rule and margin saturation, instantiated once.

Test Plan:
- Bench feature model: feat_in is registered mem[feat_addr], one-cycle latency.
- Test 1, bias-only: weights 0, biases {10,-5,300,7}, any features -> class_id=2, class_score=300, margin=255 (290 saturated).
- Test 2, tie: all weights/biases 0 -> class_id=0, class_score=0, margin=0. Also check done arrives exactly 45 edges after start is sampled and busy is high throughout.
- Test 3, feature-driven: features {100,0,0,0,0,0,0,0}, w[1][0]=2, all else 0 -> class_id=1, score=200, margin=200. Also check that feat_addr sweeps 0..7 once.
- Test 4, negative extreme: features all 255, w[0][k]=-128 for all k, others 0 -> class 0 scores -261120. Required: class_id=1, score=0, margin=0.
- Test 5, protocol: pulse start and w_we (w[1][0]=50) mid-inference -> second start is ignored, the write is dropped, and the result is unchanged from the prior run. Assert rst mid-FETCH -> no done and outputs 0; a subsequent run completes normally.
